layer_controller: RTL and testbench

LAYER_CONTROLLER -- requirements
Module: layer_controller

---
 rtl/layer_controller_if.sv | 28 ++
 rtl/layer_controller.sv | 138 +++++++++++++
 tb/tb_layer_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/layer_controller_if.sv
// Control/status bundle between a neuron datapath sequencer (slave) and its requester (master).
interface layer_controller_if #(
   parameter int IDX_W = 6,
   parameter int NEU_W = 4
);
   logic             start;
   logic             valid;
   logic             abort;
   logic [IDX_W-1:0] in_idx;
   logic [NEU_W-1:0] neuron_idx;
   logic             ld;
   logic             clr;
   logic             mult_done;
   logic             act_en;
   logic             out_we;
   logic             busy;
   logic             ready;

   modport master (
      output start, valid, abort,
      input  in_idx, neuron_idx, ld, clr, mult_done, act_en, out_we, busy, ready
   );

   modport slave (
      input  start, valid, abort,
      output in_idx, neuron_idx, ld, clr, mult_done, act_en, out_we, busy, ready
   );
endinterface

// File: rtl/layer_controller.sv
// Sequences MAC/bias/activation/write per neuron over a layer; valid=0 stalls MAC, abort cancels a pass.
// Outputs decode state (+valid) combinationally; LAYER_CTRL_ACT_EN keeps the ACT state.
module layer_controller #(
   parameter int N_INPUTS  = 10,
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = 6,
   parameter int NEU_W     = 4
) (
   input  logic                clk,
   input  logic                rst,
   layer_controller_if.slave   bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
   localparam logic [NEU_W-1:0] LAST_NEU = NEU_W'(N_NEURONS - 1);

`ifdef LAYER_CTRL_ACT_EN
   typedef enum logic [2:0] {S_IDLE, S_MAC, S_ADD, S_ACT, S_WRITE, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_MAC, S_ADD, S_WRITE, S_DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] in_idx_q, in_idx_d;
   logic [NEU_W-1:0] neu_q, neu_d;
   logic             ld_c, clr_c, mult_done_c, out_we_c, busy_c, ready_c;
`ifdef LAYER_CTRL_ACT_EN
   logic             act_en_c;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         in_idx_q <= '0;
         neu_q    <= '0;
      end else begin
         state_q  <= state_d;
         in_idx_q <= in_idx_d;
         neu_q    <= neu_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_idx_d    = in_idx_q;
      neu_d       = neu_q;
      ld_c        = 1'b0;
      clr_c       = 1'b0;
      mult_done_c = 1'b0;
      out_we_c    = 1'b0;
      busy_c      = 1'b0;
      ready_c     = 1'b0;
`ifdef LAYER_CTRL_ACT_EN
      act_en_c    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            clr_c = 1'b1;
            if (bus.start) begin
               state_d  = S_MAC;
               in_idx_d = '0;
               neu_d    = '0;
            end
         end
         S_MAC: begin
            busy_c = 1'b1;
            if (bus.valid) begin
               ld_c = 1'b1;
               if (in_idx_q == LAST_IDX) begin
                  in_idx_d = '0;
                  state_d  = S_ADD;
               end else begin
                  in_idx_d = in_idx_q + IDX_W'(1);
               end
            end
         end
         S_ADD: begin
            busy_c      = 1'b1;
            ld_c        = 1'b1;
            mult_done_c = 1'b1;
`ifdef LAYER_CTRL_ACT_EN
            state_d     = S_ACT;
`else
            state_d     = S_WRITE;
`endif
         end
`ifdef LAYER_CTRL_ACT_EN
         S_ACT: begin
            busy_c   = 1'b1;
            act_en_c = 1'b1;
            state_d  = S_WRITE;
         end
`endif
         S_WRITE: begin
            busy_c   = 1'b1;
            out_we_c = 1'b1;
            clr_c    = 1'b1;
            if (neu_q == LAST_NEU) begin
               state_d = S_DONE;
            end else begin
               state_d = S_MAC;
               neu_d   = neu_q + NEU_W'(1);
            end
         end
         S_DONE: begin
            ready_c = 1'b1;
            neu_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            in_idx_d = '0;
            neu_d    = '0;
         end
      endcase
      // Abort overrides every other transition, including the DONE->IDLE one.
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         in_idx_d = '0;
         neu_d    = '0;
      end
   end

   assign bus.in_idx     = in_idx_q;
   assign bus.neuron_idx = neu_q;
   assign bus.ld         = ld_c;
   assign bus.clr        = clr_c;
   assign bus.mult_done  = mult_done_c;
   assign bus.out_we     = out_we_c;
   assign bus.busy       = busy_c;
   assign bus.ready      = ready_c;
`ifdef LAYER_CTRL_ACT_EN
   assign bus.act_en     = act_en_c;
`else
   assign bus.act_en     = 1'b0;
`endif

endmodule

// File: tb/tb_layer_controller.sv
// Directed bench: full pass, valid stall, abort, held start, async reset, and a 1x1 layer.
module tb_layer_controller;

   localparam int NI = 10;
   localparam int NN = 4;
`ifdef LAYER_CTRL_ACT_EN
   localparam int PER     = NI + 3;
   localparam int PER1    = 1 + 3;
   localparam int ACT_EXP = NN;
`else
   localparam int PER     = NI + 2;
   localparam int PER1    = 1 + 2;
   localparam int ACT_EXP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   layer_controller_if #(.IDX_W(6), .NEU_W(4)) bus ();
   layer_controller_if #(.IDX_W(6), .NEU_W(4)) bus2 ();

   layer_controller #(.N_INPUTS(NI), .N_NEURONS(NN), .IDX_W(6), .NEU_W(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   layer_controller #(.N_INPUTS(1), .N_NEURONS(1), .IDX_W(6), .NEU_W(4)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int we_cyc[$], we_neu[$], rdy_cyc[$];
   int busy_h[$], clr_h[$], in_h[$], neu_h[$], ld_h[$];
   int act_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle 1 is the first cycle after start is sampled; history index c-1 holds cycle c.
   task automatic run(input int ncyc, input int stall_from, input int stall_len,
                      input int abort_at, input bit hold_start);
      we_cyc.delete(); we_neu.delete(); rdy_cyc.delete();
      busy_h.delete(); clr_h.delete(); in_h.delete(); neu_h.delete(); ld_h.delete();
      act_cnt = 0;
      bus.start = 1'b1; bus.valid = 1'b1; bus.abort = 1'b0;
      tick();
      for (int c = 1; c <= ncyc; c++) begin
         bus.start = hold_start;
         bus.valid = !(c >= stall_from && c < stall_from + stall_len);
         bus.abort = (c == abort_at);
         #1;
         if (bus.out_we) begin we_cyc.push_back(c); we_neu.push_back(int'(bus.neuron_idx)); end
         if (bus.ready) rdy_cyc.push_back(c);
         if (bus.act_en) act_cnt++;
         busy_h.push_back(int'(bus.busy));
         clr_h.push_back(int'(bus.clr));
         in_h.push_back(int'(bus.in_idx));
         neu_h.push_back(int'(bus.neuron_idx));
         ld_h.push_back(int'(bus.ld));
         tick();
      end
      bus.start = 1'b0; bus.valid = 1'b1; bus.abort = 1'b0;
   endtask

   initial begin
      int rdy2, rdy2_cyc, we2_cyc;
      bus.start = 1'b0; bus.valid = 1'b1; bus.abort = 1'b0;
      bus2.start = 1'b0; bus2.valid = 1'b1; bus2.abort = 1'b0;

      // Reset values, before any clock edge
      #2;
      chk("rst_clr", bus.clr, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ld", bus.ld, 0);
      chk("rst_ready", bus.ready, 0);
      chk("rst_out_we", bus.out_we, 0);
      chk("rst_in_idx", bus.in_idx, 0);
      chk("rst_neu", bus.neuron_idx, 0);
      #10 rst = 1'b0;
      tick();

      // Full pass, valid held high
      run(NN*PER + 5, 0, 0, 0, 1'b0);
      chk("A_first_ld", ld_h[0], 1);
      chk("A_first_idx", in_h[0], 0);
      chk("A_we_count", we_cyc.size(), NN);
      for (int k = 0; k < NN && k < we_cyc.size(); k++) begin
         chk($sformatf("A_we_cyc%0d", k), we_cyc[k], PER*(k+1));
         chk($sformatf("A_we_neu%0d", k), we_neu[k], k);
      end
      chk("A_rdy_count", rdy_cyc.size(), 1);
      if (rdy_cyc.size() > 0) chk("A_rdy_cyc", rdy_cyc[0], NN*PER + 1);
      chk("A_act_cnt", act_cnt, ACT_EXP);
      chk("A_done_busy", busy_h[NN*PER], 0);
      chk("A_idle_clr", clr_h[NN*PER + 1], 1);

      // Three-cycle valid stall while in_idx=5 (cycles 6..8)
      run(NN*PER + 8, 6, 3, 0, 1'b0);
      for (int c = 6; c <= 8; c++) begin
         chk($sformatf("B_stall_idx_c%0d", c), in_h[c-1], 5);
         chk($sformatf("B_stall_ld_c%0d", c), ld_h[c-1], 0);
      end
      chk("B_resume_idx", in_h[8], 5);
      chk("B_next_idx", in_h[9], 6);
      chk("B_we_count", we_cyc.size(), NN);
      for (int k = 0; k < NN && k < we_cyc.size(); k++)
         chk($sformatf("B_we_cyc%0d", k), we_cyc[k], PER*(k+1) + 3);
      chk("B_rdy_count", rdy_cyc.size(), 1);
      if (rdy_cyc.size() > 0) chk("B_rdy_cyc", rdy_cyc[0], NN*PER + 4);

      // Abort at cycle 20, neuron 1 in MAC
      run(NN*PER + 5, 0, 0, 20, 1'b0);
      chk("C_pre_busy", busy_h[19], 1);
      chk("C_pre_neu", neu_h[19], 1);
      chk("C_idle_busy", busy_h[20], 0);
      chk("C_idle_clr", clr_h[20], 1);
      chk("C_idle_idx", in_h[20], 0);
      chk("C_idle_neu", neu_h[20], 0);
      chk("C_we_count", we_cyc.size(), 1);
      chk("C_rdy_count", rdy_cyc.size(), 0);

      // start held high throughout: one ready, then a fresh pass
      run(NN*PER + 3, 0, 0, 0, 1'b1);
      chk("D_we_count", we_cyc.size(), NN);
      if (we_cyc.size() > 0) chk("D_we_first", we_cyc[0], PER);
      chk("D_rdy_count", rdy_cyc.size(), 1);
      if (rdy_cyc.size() > 0) chk("D_rdy_cyc", rdy_cyc[0], NN*PER + 1);
      chk("D_idle_busy", busy_h[NN*PER + 1], 0);
      chk("D_restart_busy", busy_h[NN*PER + 2], 1);
      chk("D_restart_idx", in_h[NN*PER + 2], 0);
      chk("D_restart_neu", neu_h[NN*PER + 2], 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      #1;
      chk("D_abort_busy", bus.busy, 0);

      // Async reset mid-ADD
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (NI) tick();
      chk("E_in_add", bus.mult_done, 1);
      #2 rst = 1'b1;
      #1;
      chk("E_rst_mult_done", bus.mult_done, 0);
      chk("E_rst_ld", bus.ld, 0);
      chk("E_rst_clr", bus.clr, 1);
      chk("E_rst_busy", bus.busy, 0);
      chk("E_rst_neu", bus.neuron_idx, 0);
      rst = 1'b0;
      rdy2 = 0;
      for (int c = 0; c < 3*PER; c++) begin
         tick();
         if (bus.ready || bus.busy) rdy2++;
      end
      chk("E_no_activity", rdy2, 0);

      // 1-input, 1-neuron layer
      rdy2 = 0; rdy2_cyc = 0; we2_cyc = 0;
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         #1;
         if (bus2.ready) begin rdy2++; rdy2_cyc = c; end
         if (bus2.out_we) we2_cyc = c;
         tick();
      end
      chk("F_rdy_count", rdy2, 1);
      chk("F_rdy_cyc", rdy2_cyc, PER1 + 1);
      chk("F_we_cyc", we2_cyc, PER1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
